alu_mul_sequencer: RTL and testbench

- Multi-cycle control client of the 8-bit ALU: drives the ALU's A, B and FunSel inputs and consumes its OutALU result and ZCNO flags.
- Computes an 8x8 -> 16-bit product by shift-and-add, issuing one ALU operation per multiplier bit.
- Sits beside the ALU in the datapath; the controller invokes it with a start/done handshake.
- The ALU itself needs no modification.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_mul_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: FunSel codes, ZCNO flag bit positions and the
// multiply sequencer state encoding.
package alu_pkg;

   localparam logic [3:0] FS_PASS_A = 4'b0000;
   localparam logic [3:0] FS_PASS_B = 4'b0001;
   localparam logic [3:0] FS_NOT_A  = 4'b0010;
   localparam logic [3:0] FS_NOT_B  = 4'b0011;
   localparam logic [3:0] FS_ADD    = 4'b0100;
   localparam logic [3:0] FS_ADDC   = 4'b0101;
   localparam logic [3:0] FS_SUB    = 4'b0110;
   localparam logic [3:0] FS_AND    = 4'b0111;
   localparam logic [3:0] FS_OR     = 4'b1000;
   localparam logic [3:0] FS_XOR    = 4'b1001;
   localparam logic [3:0] FS_NAND   = 4'b1010;
   localparam logic [3:0] FS_LSL    = 4'b1011;
   localparam logic [3:0] FS_LSR    = 4'b1100;
   localparam logic [3:0] FS_ASR    = 4'b1101;
   localparam logic [3:0] FS_CSL    = 4'b1110;
   localparam logic [3:0] FS_CSR    = 4'b1111;

   localparam int unsigned ZF = 3;
   localparam int unsigned CF = 2;
   localparam int unsigned NF = 1;
   localparam int unsigned OF = 0;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StIssue,
      StWait,
      StShift,
      StFix,
      StDone
   } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 8x8 multiplier that borrows the external ALU for each partial sum.
// Optional signed operation is enabled with `define SIGNED_MUL_EN.
module alu_mul_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned ALU_LAT = 1,
   parameter int unsigned NBITS   = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               start,
`ifdef SIGNED_MUL_EN
   input  logic               signed_op,
`endif
   input  logic [NBITS-1:0]   mcand,
   input  logic [NBITS-1:0]   mplier,
   output logic               busy,
   output logic               done,
   output logic [2*NBITS-1:0] product,
   output logic               zero,
   output logic               hi_nz,
   output logic [NBITS-1:0]   alu_a,
   output logic [NBITS-1:0]   alu_b,
   output logic [3:0]         alu_funsel,
   input  logic [NBITS-1:0]   alu_out,
   input  logic [3:0]         alu_zcno
);

   localparam int unsigned PW = 2 * NBITS;
   localparam int unsigned CW = $clog2(NBITS);
   localparam int unsigned WW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(NBITS - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(ALU_LAT - 1);

   seq_state_e       r_state;
   logic [NBITS-1:0] r_m;
   logic [NBITS-1:0] r_q;
   logic [NBITS-1:0] r_phi;
   logic [CW-1:0]    r_cnt;
   logic [WW-1:0]    r_wait;
   logic             r_busy;
   logic             r_done;
   logic [PW-1:0]    r_product;
   logic             r_zero;
   logic             r_hi_nz;
   logic [NBITS-1:0] r_alu_a;
   logic [NBITS-1:0] r_alu_b;
   logic [3:0]       r_alu_funsel;

   logic             w_c;
   logic [NBITS-1:0] w_phi_nx;
   logic [NBITS-1:0] w_q_nx;
   logic [NBITS-1:0] w_mc_in;
   logic [NBITS-1:0] w_mp_in;
   logic [PW-1:0]    w_res;
   logic             w_hi;
   logic             w_unused;

   // Pass-A leaves the ALU carry stale, so only an ADD may feed the shifted-in bit.
   assign w_c      = (r_alu_funsel == FS_ADD) & alu_zcno[CF];
   assign w_phi_nx = {w_c, alu_out[NBITS-1:1]};
   assign w_q_nx   = {alu_out[0], r_q[NBITS-1:1]};
   assign w_unused = ^{alu_zcno[ZF], alu_zcno[NF], alu_zcno[OF]};

`ifdef SIGNED_MUL_EN
   logic          r_neg;
   logic          r_sgn;
   logic [PW-1:0] w_raw;

   assign w_mc_in = (signed_op & mcand[NBITS-1])  ? (~mcand + 1'b1)  : mcand;
   assign w_mp_in = (signed_op & mplier[NBITS-1]) ? (~mplier + 1'b1) : mplier;
   assign w_raw   = {r_phi, r_q};
   assign w_res   = r_neg ? (~w_raw + 1'b1) : w_raw;
   // Signed fit: the upper byte plus the sign bit of the lower byte are all equal.
   assign w_hi    = r_sgn ? ~((&w_res[PW-1:NBITS-1]) | ~(|w_res[PW-1:NBITS-1]))
                          : (|w_res[PW-1:NBITS]);
`else
   assign w_mc_in = mcand;
   assign w_mp_in = mplier;
   assign w_res   = {w_phi_nx, w_q_nx};
   assign w_hi    = |w_res[PW-1:NBITS];
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= StIdle;
         r_m          <= '0;
         r_q          <= '0;
         r_phi        <= '0;
         r_cnt        <= '0;
         r_wait       <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_product    <= '0;
         r_zero       <= 1'b0;
         r_hi_nz      <= 1'b0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_funsel <= FS_PASS_A;
`ifdef SIGNED_MUL_EN
         r_neg        <= 1'b0;
         r_sgn        <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            StIdle: begin
               if (start) begin
                  r_m     <= w_mc_in;
                  r_q     <= w_mp_in;
                  r_phi   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= StLoad;
`ifdef SIGNED_MUL_EN
                  r_neg   <= signed_op & (mcand[NBITS-1] ^ mplier[NBITS-1]);
                  r_sgn   <= signed_op;
`endif
               end
            end
            StLoad: begin
               r_cnt        <= '0;
               r_alu_a      <= r_phi;
               r_alu_b      <= r_m;
               r_alu_funsel <= r_q[0] ? FS_ADD : FS_PASS_A;
               r_state      <= StIssue;
            end
            StIssue: begin
               r_wait  <= '0;
               r_state <= StWait;
            end
            StWait: begin
               if (r_wait == WAIT_LAST) begin
                  r_state <= StShift;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            StShift: begin
               r_phi <= w_phi_nx;
               r_q   <= w_q_nx;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
`ifdef SIGNED_MUL_EN
                  r_state <= StFix;
`else
                  r_product <= w_res;
                  r_zero    <= (w_res == '0);
                  r_hi_nz   <= w_hi;
                  r_done    <= 1'b1;
                  r_state   <= StDone;
`endif
               end else begin
                  r_alu_a      <= w_phi_nx;
                  r_alu_funsel <= w_q_nx[0] ? FS_ADD : FS_PASS_A;
                  r_state      <= StIssue;
               end
            end
            StFix: begin
               r_product <= w_res;
               r_zero    <= (w_res == '0);
               r_hi_nz   <= w_hi;
               r_done    <= 1'b1;
               r_state   <= StDone;
            end
            StDone: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign product    = r_product;
   assign zero       = r_zero;
   assign hi_nz      = r_hi_nz;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_funsel = r_alu_funsel;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: behavioural ALU stand-ins, a cycle-level reference
// model checked every cycle, plus directed literal cases.
module tb_alu_mul_sequencer;
   import alu_pkg::*;

`ifdef SIGNED_MUL_EN
   localparam bit SGN_BUILD = 1'b1;
   localparam int EXTRA     = 1;
`else
   localparam bit SGN_BUILD = 1'b0;
   localparam int EXTRA     = 0;
`endif
   localparam int LAT1 = 1;
   localparam int LAT2 = 2;
   localparam int L1   = 2 + 8 * (LAT1 + 2) + EXTRA;
   localparam int L2   = 2 + 8 * (LAT2 + 2) + EXTRA;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sop = 1'b0;
   always #5 clk = ~clk;

   logic        start1 = 1'b0, start2 = 1'b0;
   logic [7:0]  mc1 = '0, mp1 = '0, mc2 = '0, mp2 = '0;
   logic        busy1, done1, zero1, hinz1, busy2, done2, zero2, hinz2;
   logic [15:0] prod1, prod2;
   logic [7:0]  a1, b1, a2, b2;
   logic [3:0]  fs1, fs2;
   logic [7:0]  out1 = '0, out2 = '0;
   logic [3:0]  zcno1 = '0, zcno2 = '0;
   logic [11:0] stage2 = '0;

   int n_tests = 0;
   int n_fail  = 0;

   alu_mul_sequencer #(.ALU_LAT(LAT1), .NBITS(8)) u_dut1 (
      .CLK(clk), .RST(rst), .start(start1),
`ifdef SIGNED_MUL_EN
      .signed_op(sop),
`endif
      .mcand(mc1), .mplier(mp1), .busy(busy1), .done(done1), .product(prod1),
      .zero(zero1), .hi_nz(hinz1), .alu_a(a1), .alu_b(b1), .alu_funsel(fs1),
      .alu_out(out1), .alu_zcno(zcno1)
   );

   alu_mul_sequencer #(.ALU_LAT(LAT2), .NBITS(8)) u_dut2 (
      .CLK(clk), .RST(rst), .start(start2),
`ifdef SIGNED_MUL_EN
      .signed_op(sop),
`endif
      .mcand(mc2), .mplier(mp2), .busy(busy2), .done(done2), .product(prod2),
      .zero(zero2), .hi_nz(hinz2), .alu_a(a2), .alu_b(b2), .alu_funsel(fs2),
      .alu_out(out2), .alu_zcno(zcno2)
   );

   // ALU stand-in: returns {Z,C,N,O,out}; pass ops keep the previous carry.
   function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] fs, input logic cprev);
      logic [8:0] s;
      logic [7:0] o;
      logic c, ov;
      s = 9'd0; ov = 1'b0; c = cprev;
      if (fs == FS_ADD) begin
         s  = {1'b0, a} + {1'b0, b};
         o  = s[7:0];
         c  = s[8];
         ov = (a[7] == b[7]) && (o[7] != a[7]);
      end else if (fs == FS_PASS_A) begin
         o = a;
      end else begin
         o = a ^ b;
      end
      return {(o == 8'd0), c, o[7], ov, o};
   endfunction

   always @(posedge clk) {zcno1, out1} <= alu_f(a1, b1, fs1, zcno1[CF]);
   always @(posedge clk) begin
      stage2         <= alu_f(a2, b2, fs2, stage2[10]);
      {zcno2, out2}  <= stage2;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Reference model for DUT1, advanced at each rising edge.
   int          cyc = 0, acc = 0;
   bit          m_act = 1'b0, rst_seen = 1'b0;
   logic [7:0]  m_mc = '0, m_mp = '0;
   logic [15:0] pend_p = '0, last_p = '0;
   bit          pend_z = 1'b0, pend_h = 1'b0, last_z = 1'b0, last_h = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_act = 1'b0; rst_seen = 1'b1;
         last_p = '0; last_z = 1'b0; last_h = 1'b0;
      end else begin
         rst_seen = 1'b0;
         if (start1 && (!m_act || (cyc - acc) >= L1 + 1)) begin
            int sa, sb, r;
            bit sg;
            sg    = sop && SGN_BUILD;
            acc   = cyc;
            m_act = 1'b1;
            if (sg) begin
               sa   = int'($signed(mc1));
               sb   = int'($signed(mp1));
               r    = sa * sb;
               m_mc = 8'((sa < 0) ? -sa : sa);
               m_mp = 8'((sb < 0) ? -sb : sb);
               pend_h = (r < -128) || (r > 127);
            end else begin
               m_mc = mc1;
               m_mp = mp1;
               r    = int'(mc1) * int'(mp1);
               pend_h = r > 255;
            end
            pend_p = 16'(r);
            pend_z = (pend_p == 16'd0);
         end
      end
   end

   always @(negedge clk) begin
      int k, i, s;
      bit eb, ed;
      k  = m_act ? (cyc - acc + 1) : 0;
      eb = m_act && k <= L1;
      ed = m_act && k == L1;
      if (ed) begin
         last_p = pend_p; last_z = pend_z; last_h = pend_h;
      end
      chk("busy", 32'(busy1), 32'(eb));
      chk("done", 32'(done1), 32'(ed));
      if (!eb || ed) begin
         chk("product", 32'(prod1), 32'(last_p));
         chk("zero", 32'(zero1), 32'(last_z));
         chk("hi_nz", 32'(hinz1), 32'(last_h));
      end
      if (rst_seen) begin
         chk("rst_alu_a", 32'(a1), 32'd0);
         chk("rst_alu_b", 32'(b1), 32'd0);
         chk("rst_funsel", 32'(fs1), 32'd0);
      end
      if (eb && k >= 2 && ((k - 2) % (LAT1 + 2)) == 0 && (k - 2) / (LAT1 + 2) < 8) begin
         i = (k - 2) / (LAT1 + 2);
         s = int'(m_mc) * (int'(m_mp) & ((1 << i) - 1));
         chk("issue_funsel", 32'(fs1), 32'(m_mp[i] ? FS_ADD : FS_PASS_A));
         chk("issue_alu_b", 32'(b1), 32'(m_mc));
         chk("issue_alu_a", 32'(a1), 32'((s >> i) & 255));
      end
   end

   task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic [15:0] exp_p, input logic exp_h,
                         input int lat, input string nm);
      int k;
      @(negedge clk);
      sop = s;
      if (sel == 1) begin start1 = 1'b1; mc1 = a; mp1 = b; end
      else begin start2 = 1'b1; mc2 = a; mp2 = b; end
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
      k = 1;
      while (!((sel == 1) ? done1 : done2) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_latency"}, 32'(k), 32'(lat));
      chk({nm, "_product"}, 32'((sel == 1) ? prod1 : prod2), 32'(exp_p));
      chk({nm, "_zero"}, 32'((sel == 1) ? zero1 : zero2), 32'(exp_p == 16'd0));
      chk({nm, "_hi_nz"}, 32'((sel == 1) ? hinz1 : hinz2), 32'(exp_h));
   endtask

   function automatic logic [7:0] pick();
      case ($urandom_range(0, 5))
         0:       return 8'h00;
         1:       return 8'hFF;
         2:       return 8'h80;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      int k, dones;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy1), 32'd0);
      chk("reset_product", 32'(prod1), 32'd0);
      rst = 1'b0;

      run_op(1, 8'd13, 8'd11, 1'b0, 16'd143, 1'b0, L1, "13x11");
      run_op(1, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1, L1, "ffxff");
      run_op(1, 8'h5A, 8'h00, 1'b0, 16'h0000, 1'b0, L1, "5ax00");
      run_op(1, 8'd3, 8'd7, 1'b0, 16'd21, 1'b0, L1, "b2b_3x7");
      run_op(1, 8'd200, 8'd2, 1'b0, 16'd400, 1'b1, L1, "b2b_200x2");

      // Starts during an operation are ignored; reset aborts with no done.
      @(negedge clk);
      start1 = 1'b1; mc1 = 8'd9; mp1 = 8'd9;
      @(negedge clk);
      start1 = 1'b0;
      for (k = 2; k <= 13; k++) begin
         @(negedge clk);
         start1 = (k == 5 || k == 10);
         mc1    = 8'd77;
         rst    = (k == 12);
         if (k == 13) begin
            chk("abort_busy", 32'(busy1), 32'd0);
            chk("abort_product", 32'(prod1), 32'd0);
            chk("abort_funsel", 32'(fs1), 32'd0);
         end
      end
      start1 = 1'b0;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done1) dones++;
      end
      chk("abort_no_done", 32'(dones), 32'd0);

      run_op(2, 8'd3, 8'd7, 1'b0, 16'd21, 1'b0, L2, "lat2_3x7");
      run_op(2, 8'd200, 8'd2, 1'b0, 16'd400, 1'b1, L2, "lat2_200x2");

`ifdef SIGNED_MUL_EN
      run_op(1, 8'hFD, 8'd5, 1'b1, 16'hFFF1, 1'b0, L1, "sgn_m3x5");
      run_op(1, 8'h80, 8'h80, 1'b1, 16'h4000, 1'b1, L1, "sgn_m128xm128");
`endif

      repeat (1500) begin
         @(negedge clk);
         start1 = ($urandom_range(0, 3) == 0);
         mc1    = pick();
         mp1    = pick();
         sop    = 1'($urandom);
         rst    = ($urandom_range(0, 299) == 0);
      end
      start1 = 1'b0;
      rst    = 1'b0;
      repeat (40) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
